// File: rtl/pipe_hazard_tracker.sv
// Carries the decoded write-back/memory control of each instruction from ID
// through the EX, MEM and WB pipeline registers. Returns the stage-tagged
// destination info for forwarding and load-use detection, drives the
// register-file write port and keeps stall/retire counters.
module pipe_hazard_tracker #(
  parameter int CNT_W  = 32,
  parameter int RA_REG = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wreg,
  input  logic             m2reg,
  input  logic             wmem,
  input  logic             regrt,
  input  logic             jal,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic             stall,
  output logic [4:0]       ern,
  output logic             ewreg,
  output logic             em2reg,
  output logic             ewmem,
  output logic [4:0]       mrn,
  output logic             mwreg,
  output logic             mm2reg,
  output logic             mwmem,
  output logic [4:0]       wrn,
  output logic             wwreg,
  output logic             wm2reg,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [4:0]       RA_RN   = 5'(RA_REG);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0] id_rn;
  logic       id_wreg;

  // Destination select in ID; a write to r0 is squashed here so it never
  // shows up as a forwarding source or a register-file write downstream.
  always_comb begin
    id_rn   = jal ? RA_RN : (regrt ? rt : rd);
    id_wreg = wreg & (id_rn != 5'd0);
  end

  // EX stage register; a load-use stall inserts a bubble instead of the ID op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ern    <= 5'd0;
      ewreg  <= 1'b0;
      em2reg <= 1'b0;
      ewmem  <= 1'b0;
    end else if (stall) begin
      ern    <= 5'd0;
      ewreg  <= 1'b0;
      em2reg <= 1'b0;
      ewmem  <= 1'b0;
    end else begin
      ern    <= id_rn;
      ewreg  <= id_wreg;
      em2reg <= m2reg;
      ewmem  <= wmem;
    end
  end

  // MEM stage register; always advances so the load ahead of a bubble proceeds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mrn    <= 5'd0;
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
    end else begin
      mrn    <= ern;
      mwreg  <= ewreg;
      mm2reg <= em2reg;
      mwmem  <= ewmem;
    end
  end

  // WB stage register; memory-write flag is dropped as nothing past MEM uses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrn    <= 5'd0;
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
    end else begin
      wrn    <= mrn;
      wwreg  <= mwreg;
      wm2reg <= mm2reg;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  // Saturating count of completed register-file writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (wwreg && (retire_cnt != '1)) begin
      retire_cnt <= retire_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Directed-vector bench with a scoreboard: the stimulus process pushes the
// hand-computed post-edge state for each vector, a monitor pops and compares.
module tb_pipe_hazard_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wreg = 0, m2reg = 0, wmem = 0, regrt = 0, jal = 0, stall = 0;
  logic [4:0] rt = '0, rd = '0;
  logic sat_stall = 0;

  logic [4:0]  ern, mrn, wrn;
  logic        ewreg, em2reg, ewmem, mwreg, mm2reg, mwmem, wwreg, wm2reg;
  logic [31:0] stall_cnt, retire_cnt;

  logic [4:0]  s_ern, s_mrn, s_wrn;
  logic        s_ewreg, s_em2reg, s_ewmem, s_mwreg, s_mm2reg, s_mwmem, s_wwreg, s_wm2reg;
  logic [3:0]  s_stall_cnt, s_retire_cnt;

  always #5 clk = ~clk;

  pipe_hazard_tracker #(.CNT_W(32), .RA_REG(31)) u_dut (
    .clk(clk), .rst(rst), .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .regrt(regrt),
    .jal(jal), .rt(rt), .rd(rd), .stall(stall),
    .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .wrn(wrn), .wwreg(wwreg), .wm2reg(wm2reg),
    .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
  );

  pipe_hazard_tracker #(.CNT_W(4), .RA_REG(31)) u_sat (
    .clk(clk), .rst(rst), .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .regrt(regrt),
    .jal(jal), .rt(rt), .rd(rd), .stall(sat_stall),
    .ern(s_ern), .ewreg(s_ewreg), .em2reg(s_em2reg), .ewmem(s_ewmem),
    .mrn(s_mrn), .mwreg(s_mwreg), .mm2reg(s_mm2reg), .mwmem(s_mwmem),
    .wrn(s_wrn), .wwreg(s_wwreg), .wm2reg(s_wm2reg),
    .stall_cnt(s_stall_cnt), .retire_cnt(s_retire_cnt)
  );

  typedef struct packed {
    logic [7:0]  ex;   // {rn, wreg, m2reg, wmem}
    logic [7:0]  mem;  // {rn, wreg, m2reg, wmem}
    logic [6:0]  wb;   // {rn, wreg, m2reg}
    logic [31:0] sc;
    logic [31:0] rc;
    logic [3:0]  sat;
  } exp_t;

  typedef struct {
    logic       rst, wreg, m2reg, wmem, regrt, jal, stall, sat_stall;
    logic [4:0] rt, rd;
    exp_t       e;
  } row_t;

  row_t rows[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   row_idx = 0;

  function automatic logic [7:0] st(input logic [4:0] rn, input logic w, input logic m, input logic wm);
    return {rn, w, m, wm};
  endfunction

  function automatic logic [6:0] wbv(input logic [4:0] rn, input logic w, input logic m);
    return {rn, w, m};
  endfunction

  task automatic add(input logic r, input logic w, input logic m, input logic wm, input logic rg,
                     input logic j, input logic [4:0] t, input logic [4:0] d, input logic s,
                     input logic [7:0] ex, input logic [7:0] mem, input logic [6:0] wb,
                     input logic [31:0] sc, input logic [31:0] rc);
    row_t x;
    x.rst = r; x.wreg = w; x.m2reg = m; x.wmem = wm; x.regrt = rg; x.jal = j;
    x.rt = t; x.rd = d; x.stall = s; x.sat_stall = 1'b0;
    x.e = '{ex: ex, mem: mem, wb: wb, sc: sc, rc: rc, sat: 4'd0};
    rows.push_back(x);
  endtask

  task automatic drive(input row_t x);
    rst = x.rst; wreg = x.wreg; m2reg = x.m2reg; wmem = x.wmem; regrt = x.regrt;
    jal = x.jal; rt = x.rt; rd = x.rd; stall = x.stall; sat_stall = x.sat_stall;
  endtask

  task automatic chk(input string nm, input int idx, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec%0d: got %0h expected %0h", nm, idx, got, want);
    end
  endtask

  // Monitor: after each active edge compare DUT state with the queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ex",     row_idx, 64'({ern, ewreg, em2reg, ewmem}), 64'(e.ex));
      chk("mem",    row_idx, 64'({mrn, mwreg, mm2reg, mwmem}), 64'(e.mem));
      chk("wb",     row_idx, 64'({wrn, wwreg, wm2reg}),        64'(e.wb));
      chk("stall",  row_idx, 64'(stall_cnt),                   64'(e.sc));
      chk("retire", row_idx, 64'(retire_cnt),                  64'(e.rc));
      chk("sat",    row_idx, 64'(s_stall_cnt),                 64'(e.sat));
      row_idx++;
    end
  end

  initial begin
    //   rst w m wm rg j  rt  rd  s   EX               MEM              WB                sc rc
    add(1, 1,0,0, 0,0, 0,  7, 0, st(0,0,0,0),  st(0,0,0,0),  wbv(0,0,0),  0, 0); // 0 held in reset
    add(0, 1,0,0, 0,0, 0,  5, 0, st(5,1,0,0),  st(0,0,0,0),  wbv(0,0,0),  0, 0); // 1 add r5
    add(0, 0,0,0, 0,0, 0,  0, 0, st(0,0,0,0),  st(5,1,0,0),  wbv(0,0,0),  0, 0); // 2
    add(0, 0,0,0, 0,0, 0,  0, 0, st(0,0,0,0),  st(0,0,0,0),  wbv(5,1,0),  0, 0); // 3
    add(0, 0,0,0, 0,0, 0,  0, 0, st(0,0,0,0),  st(0,0,0,0),  wbv(0,0,0),  0, 1); // 4 retired
    add(0, 1,1,0, 1,0, 8,  3, 0, st(8,1,1,0),  st(0,0,0,0),  wbv(0,0,0),  0, 1); // 5 lw r8
    add(0, 1,0,0, 0,0, 0,  9, 1, st(0,0,0,0),  st(8,1,1,0),  wbv(0,0,0),  1, 1); // 6 stall bubble
    add(0, 1,0,0, 0,0, 0,  9, 0, st(9,1,0,0),  st(0,0,0,0),  wbv(8,1,1),  1, 1); // 7 add r9 again
    add(0, 0,0,0, 0,0, 0,  0, 0, st(0,0,0,0),  st(9,1,0,0),  wbv(0,0,0),  1, 2); // 8
    add(0, 1,0,0, 0,1, 0,  0, 1, st(0,0,0,0),  st(0,0,0,0),  wbv(9,1,0),  2, 2); // 9 jal+stall
    add(0, 1,0,0, 0,1, 0,  0, 0, st(31,1,0,0), st(0,0,0,0),  wbv(0,0,0),  2, 3); // 10 jal
    add(0, 1,0,0, 1,0, 0,  4, 0, st(0,0,0,0),  st(31,1,0,0), wbv(0,0,0),  2, 3); // 11 addi r0
    add(0, 0,0,1, 1,0, 6,  0, 0, st(6,0,0,1),  st(0,0,0,0),  wbv(31,1,0), 2, 3); // 12 sw
    add(0, 0,0,0, 0,0, 0,  0, 0, st(0,0,0,0),  st(6,0,0,1),  wbv(0,0,0),  2, 4); // 13
    add(0, 1,0,1, 0,0, 0, 12, 0, st(12,1,0,1), st(0,0,0,0),  wbv(6,0,0),  2, 4); // 14 wreg+wmem
    add(0, 0,0,0, 0,0, 0,  0, 1, st(0,0,0,0),  st(12,1,0,1), wbv(0,0,0),  3, 4); // 15 stall
    add(0, 0,0,0, 0,0, 0,  0, 1, st(0,0,0,0),  st(0,0,0,0),  wbv(12,1,0), 4, 4); // 16 stall again
    add(0, 0,0,0, 0,0, 0,  0, 0, st(0,0,0,0),  st(0,0,0,0),  wbv(0,0,0),  4, 5); // 17
    add(0, 1,0,0, 0,0, 0, 20, 0, st(20,1,0,0), st(0,0,0,0),  wbv(0,0,0),  4, 5); // 18 add r20
    add(0, 0,0,0, 0,0, 0,  0, 0, st(0,0,0,0),  st(20,1,0,0), wbv(0,0,0),  4, 5); // 19
    add(0, 0,0,0, 0,0, 0,  0, 0, st(0,0,0,0),  st(0,0,0,0),  wbv(20,1,0), 4, 5); // 20
    add(1, 1,1,1, 1,0,13, 22, 1, st(0,0,0,0),  st(0,0,0,0),  wbv(0,0,0),  0, 0); // 21 held in reset
    add(0, 1,0,0, 1,0,17,  2, 0, st(17,1,0,0), st(0,0,0,0),  wbv(0,0,0),  0, 0); // 22 first after release
    add(0, 0,0,0, 0,0, 0,  0, 0, st(0,0,0,0),  st(17,1,0,0), wbv(0,0,0),  0, 0); // 23
    add(0, 0,0,0, 0,0, 0,  0, 0, st(0,0,0,0),  st(0,0,0,0),  wbv(17,1,0), 0, 0); // 24
    add(0, 0,0,0, 0,0, 0,  0, 0, st(0,0,0,0),  st(0,0,0,0),  wbv(0,0,0),  0, 1); // 25

    // Saturation of the 4-bit instance: count 1..15 then hold at 15.
    for (int k = 1; k <= 20; k++) begin
      row_t x;
      x.rst = 0; x.wreg = 0; x.m2reg = 0; x.wmem = 0; x.regrt = 0; x.jal = 0;
      x.rt = '0; x.rd = '0; x.stall = 0; x.sat_stall = 1'b1;
      x.e = '{ex: '0, mem: '0, wb: '0, sc: 32'd0, rc: 32'd1, sat: (k > 15) ? 4'd15 : 4'(k)};
      rows.push_back(x);
    end

    for (int i = 0; i < rows.size(); i++) begin
      if (i == 21) begin
        // Asynchronous reset in the middle of a cycle with a write in WB.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_wwreg", i, 64'(wwreg), 64'd0);
        chk("async_rst_all", i,
            64'({ern, ewreg, em2reg, ewmem, mrn, mwreg, mm2reg, mwmem, wrn, wwreg, wm2reg}), 64'd0);
        chk("async_rst_cnt", i, {stall_cnt, retire_cnt}, 64'd0);
      end
      @(negedge clk);
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
    end

    @(negedge clk);
    sat_stall = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_tracker.md
# pipe_hazard_tracker

Sequential counterpart to the ID-stage control decoder. It captures the decoded write-back/memory control of each instruction leaving ID and carries it through the EX, MEM and WB pipeline registers. It returns the stage-tagged destination information the decoder consumes for forwarding and load-use stall detection (ern/ewreg/em2reg, mrn/mwreg/mm2reg). It also drives the register-file write port controls and keeps stall and retire performance counters.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters
- RA_REG, 31, destination register number forced for jal

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- wreg  input  1  ID: instruction writes a register
- m2reg  input  1  ID: write-back data comes from memory (lw)
- wmem  input  1  ID: instruction writes memory (sw)
- regrt  input  1  ID: destination is rt, not rd
- jal  input  1  ID: destination is RA_REG
- rt  input  5  ID: instruction rt field
- rd  input  5  ID: instruction rd field
- stall  input  1  ID: load-use stall from the decoder (its wpcir output)
- ern  output  5  EX destination register
- ewreg  output  1  EX writes a register
- em2reg  output  1  EX is a load
- ewmem  output  1  EX writes memory
- mrn  output  5  MEM destination register
- mwreg  output  1  MEM writes a register
- mm2reg  output  1  MEM is a load
- mwmem  output  1  MEM writes memory (data-memory write enable)
- wrn  output  5  WB destination register (register-file write address)
- wwreg  output  1  WB register-file write enable
- wm2reg  output  1  WB write-back mux select
- stall_cnt  output  CNT_W  number of stall cycles since reset
- retire_cnt  output  CNT_W  number of retired register-writing instructions since reset

## Operation
- Destination select in ID, combinational: rn = jal ? RA_REG : (regrt ? rt : rd).
- Register chain ID→EX→MEM→WB. Each stage holds {rn, wreg, m2reg, wmem}. All stages advance every cycle. There is no global hold, because the decoder's stall only freezes PC and IF/ID.
- Bubble insertion: when stall=1, EX captures rn=0, wreg=0, m2reg=0, wmem=0, whatever the ID inputs are. MEM and WB still advance normally, so the load in flight proceeds.
- Zero-register squash: when rn=0, ewreg is captured as 0 even if wreg=1. The same 0 then propagates down the chain, so writes to r0 never reach the register file or the forwarding logic.
- wmem and wreg both set (illegal decode): both are captured as given. The block does not arbitrate this case.
- stall_cnt increments by 1 on each rising edge where stall=1.
- retire_cnt increments by 1 on each rising edge where wwreg=1, i.e. when the WB stage completes a write.
- Both counters saturate at all-ones and do not wrap.

## Timing
- Reset (rst=1, asynchronous): every stage register clears to 0, so every output is 0, including the counters. Outputs stay 0 while rst is held.
- Deassertion of rst is synchronised by the surrounding system. On the first edge after release, EX loads from ID.
- Latency from an ID instruction: ern/ewreg/em2reg/ewmem valid 1 cycle later, mrn/mwreg/mm2reg/mwmem 2 cycles later, wrn/wwreg/wm2reg 3 cycles later.
- All outputs are registered or counter outputs. There are no combinational paths from inputs to outputs.
- Back-to-back stall cycles each insert one bubble and each count one in stall_cnt.
- Stall asserted together with jal in ID: the bubble wins and the jal is not captured. The decoder presents the jal again on the next cycle.
- Reset asserted mid-flight: all in-flight stages are discarded with no partial write. wwreg drops to 0 immediately, asynchronously.
- Counter at saturation plus a new increment event: the value holds at all-ones.

## Test plan
- Reset: drive random ID inputs and assert rst mid-cycle. All outputs go to 0 at once. After release, ern equals the ID destination one edge later.
- Propagation: an add with rd=5, regrt=0, wreg=1 at cycle 0 gives ern=5/ewreg=1 at cycle 1, mrn=5/mwreg=1 at cycle 2, and wrn=5/wwreg=1 at cycle 3. retire_cnt becomes 1 at cycle 4.
- Load-use: a lw with rt=8, regrt=1, m2reg=1 is followed by stall=1 for one cycle. The chain reads EX=lw, MEM=empty, then EX=bubble (ewreg=0, ern=0), MEM=lw (mm2reg=1, mrn=8). stall_cnt becomes 1.
- jal and r0: jal=1, regrt=0, rd=0 gives ern=31 and ewreg=1. An addi with regrt=1, rt=0, wreg=1 gives ern=0 and ewreg=0, and wwreg=0 three cycles later.
- sw: wmem=1, wreg=0 gives ewmem=1 at +1 and mwmem=1 at +2. wwreg stays 0 and retire_cnt does not change.
- Saturation: with CNT_W=4, hold stall=1 for 20 cycles. stall_cnt reaches 15 and stays there.
